preg_freelist_ckpt: RTL and testbench
=====================================

// Module: preg_freelist_ckpt
// PURPOSE
//  Parametrised physical-register free list for the rename stage: a circular queue of free preg indices.
//  Hands out up to ALLOC_W pregs per cycle to rename and accepts up to FREE_W released pregs per cycle from commit.
//  Supports walk-back rollback and, optionally, single-cycle checkpoint restore on redirect.
//  Sits between rename (allocation) and the ROB commit path (release).
// PARAMETERS
//  PREG_NUM  128  physical registers; power of two; queue has PREG_NUM slots
//  ARCH_NUM  32   architectural regs; pregs 0..ARCH_NUM-1 are mapped at reset, never in list at reset
//  ALLOC_W   4    allocation lanes per cycle
//  FREE_W    4    release lanes per cycle
//  SNAP_NUM  8    checkpoint slots (used only with FREELIST_SNAPSHOT_EN)
//  Derived: IDX_W=$clog2(PREG_NUM); PTR_W=IDX_W+1 (wrap bit); DEPTH=PREG_NUM-ARCH_NUM
// PORTS
//  clk           in   1                 clock, single domain
//  rst           in   1                 synchronous reset, active-high
//  alloc_req     in   ALLOC_W           per-lane request mask, need not be contiguous
//  stall         in   1                 downstream stall; suppresses allocation this cycle
//  alloc_ready   out  1                 enough free entries for all requested lanes, no walk in progress
//  alloc_preg    out  ALLOC_W*IDX_W     preg for each requesting lane, valid same cycle (combinational)
//  free_en       in   FREE_W            per-lane release valid, need not be contiguous
//  free_preg     in   FREE_W*IDX_W      released preg indices
//  walk_en       in   1                 rollback: return walk_num most recently allocated pregs
//  walk_num      in   $clog2(ALLOC_W)+1 entries to return this cycle
//  free_count    out  PTR_W             current number of free entries (registered)
//  err           out  1                 sticky: overflow/underflow detected; cleared only by rst
//  snap_take     in   1                 [SNAPSHOT_EN] capture post-allocation head into slot snap_id
//  snap_id       in   $clog2(SNAP_NUM)  [SNAPSHOT_EN] slot for take
//  snap_restore  in   1                 [SNAPSHOT_EN] restore head from slot restore_id
//  restore_id    in   $clog2(SNAP_NUM)  [SNAPSHOT_EN] slot for restore
// BEHAVIOUR
//  Reset: list[i]=ARCH_NUM+i for i<DEPTH, others 0; head=0; tail=DEPTH; free_count=DEPTH; err=0; snapshots=0.
//  free_count = tail-head (PTR_W modular arithmetic); never stored separately.
//  Allocation:
//   - alloc_ready = (free_count >= popcount(alloc_req)) && !walk_en && !snap_restore.
//   - alloc_preg[i] = list[(head + prefix_popcount(alloc_req, i)) mod PREG_NUM]; don't-care when alloc_req[i]=0.
//   - fire = alloc_ready && !stall && |alloc_req; on fire head += popcount(alloc_req) next edge.
//   - All-or-nothing: no partial allocation.
//  Release:
//   - Every cycle, each free_en[j] writes list[(tail + prefix_popcount(free_en, j)) mod PREG_NUM].
//   - tail += popcount(free_en).
//   - Release is independent of stall, walk and restore.
//  Walk:
//   - walk_en: head -= walk_num; allocation blocked that cycle.
//   - Entries below head are never overwritten until re-freed, so returned pregs are identical.
//  Priority on head: snap_restore > walk_en > fire. Restore and walk in the same cycle: walk is ignored.
//  err sets on any of:
//   - release would make free_count > DEPTH;
//   - walk would move head before the oldest unreleased allocation (free_count+walk_num > DEPTH);
//   - fire with popcount > free_count (cannot happen if the handshake is obeyed).
//  Wrap-around: all indices mod PREG_NUM; wrap bit distinguishes full queue from empty queue.
//  Latency: alloc_preg is 0-cycle; head/tail/free_count update 1 cycle after the event.
//  Mid-operation rst: returns to reset state next edge regardless of other inputs.
// CONFIGURATION
//  FREELIST_SNAPSHOT_EN defined:
//   - SNAP_NUM x PTR_W head checkpoint array plus snap_* and restore_* ports.
//   - snap_take stores head after this cycle's fire (head + popcount if fired).
//   - snap_restore sets head = snap[restore_id] in one cycle; free_count becomes tail - snap head.
//   - Same-cycle take and restore: restore wins; take is dropped.
//  FREELIST_SNAPSHOT_EN undefined:
//   - No checkpoint storage; snap_take, snap_id, snap_restore and restore_id ports are absent.
//   - Recovery is by walk_en only.
// TESTING
//  T1 reset, alloc_req=4'b1111, stall=0 -> alloc_preg=32,33,34,35, ready=1; next cycle free_count=92.
//  T2 alloc_req=4'b1010 -> lane1=32, lane3=33; head+=2.
//  T3 drain to free_count=2, alloc_req=4'b0111 -> ready=0, head unchanged; free_en=4'b0001 preg 7 -> next cycle ready=1.
//  T4 alloc 3 (32,33,34), walk_en walk_num=3, with alloc_req=4'b1111 that cycle -> ready=0; next alloc returns 32,33,34 again.
//  T5 free 4 pregs when free_count=DEPTH -> err=1 and stays 1 until rst.
//  T6 [SNAPSHOT_EN] snap_take id2 after 4 allocs, alloc 8 more, snap_restore id2 -> free_count=92; next alloc starts at preg 36.

Source files
------------

// File: rtl/preg_freelist_ckpt.sv
// -----------------------------------------------------------------------------
// preg_freelist_ckpt
//
// Physical-register free list for the rename stage. A circular queue of
// PREG_NUM slots holds the free preg indices between head (next to allocate)
// and tail (next slot to fill). Rename takes up to ALLOC_W pregs per cycle
// (all-or-nothing), and commit returns up to FREE_W pregs per cycle. Misspeculation
// recovery uses walk-back of head. When the optional snapshot feature is built,
// recovery can also restore head from a checkpoint in a single cycle.
//
// Build option:
//   FREELIST_SNAPSHOT_EN  when defined, adds SNAP_NUM head checkpoints and the
//                         snap_take/snap_id/snap_restore/restore_id ports.
//
// Ports:
//   clk           clock
//   rst           synchronous reset, active-high
//   alloc_req     per-lane allocation request mask (need not be contiguous)
//   stall         downstream stall, suppresses allocation this cycle
//   alloc_ready   enough free entries for all requested lanes, no recovery active
//   alloc_preg    preg per requesting lane, combinational (lane i at [i*IDX_W +: IDX_W])
//   free_en       per-lane release valid (need not be contiguous)
//   free_preg     released preg per lane
//   walk_en       roll head back by walk_num entries
//   walk_num      number of entries to roll back
//   free_count    number of free entries (tail - head)
//   err           sticky overflow/underflow flag, cleared only by rst
//   snap_take     [snapshot] capture post-allocation head into slot snap_id
//   snap_id       [snapshot] slot written by snap_take
//   snap_restore  [snapshot] restore head from slot restore_id
//   restore_id    [snapshot] slot read by snap_restore
// -----------------------------------------------------------------------------
module preg_freelist_ckpt #(
    parameter int PREG_NUM = 128,
    parameter int ARCH_NUM = 32,
    parameter int ALLOC_W  = 4,
    parameter int FREE_W   = 4,
    parameter int SNAP_NUM = 8,
    localparam int IDX_W   = $clog2(PREG_NUM),
    localparam int PTR_W   = IDX_W + 1,
    localparam int DEPTH   = PREG_NUM - ARCH_NUM,
    localparam int AC_W    = $clog2(ALLOC_W) + 1,
    localparam int FC_W    = $clog2(FREE_W) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ALLOC_W-1:0]       alloc_req,
    input  logic                     stall,
    output logic                     alloc_ready,
    output logic [ALLOC_W*IDX_W-1:0] alloc_preg,
    input  logic [FREE_W-1:0]        free_en,
    input  logic [FREE_W*IDX_W-1:0]  free_preg,
    input  logic                     walk_en,
    input  logic [AC_W-1:0]          walk_num,
    output logic [PTR_W-1:0]         free_count,
    output logic                     err
`ifdef FREELIST_SNAPSHOT_EN
    ,
    input  logic                         snap_take,
    input  logic [$clog2(SNAP_NUM)-1:0]  snap_id,
    input  logic                         snap_restore,
    input  logic [$clog2(SNAP_NUM)-1:0]  restore_id
`endif
);

    // Elaboration-time parameter sanity checks.
    if (((PREG_NUM & (PREG_NUM - 1)) != 0) || (ARCH_NUM >= PREG_NUM) ||
        (SNAP_NUM < 1) || (AC_W > PTR_W)) begin : g_param_check
        $error("preg_freelist_ckpt: illegal parameter combination");
    end

    // Queue storage and pointers. Pointers carry a wrap bit so that
    // tail - head distinguishes a full queue from an empty one.
    logic [IDX_W-1:0] r_list [PREG_NUM];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic             r_err;

    logic [PTR_W-1:0] w_free_count;
    logic [AC_W-1:0]  w_alloc_cnt;
    logic [FC_W-1:0]  w_free_cnt;
    logic [IDX_W-1:0] w_alloc_idx [ALLOC_W];
    logic [IDX_W-1:0] w_free_idx  [FREE_W];
    logic             w_restore;
    logic             w_ready;
    logic             w_fire;
    logic             w_walk;
    logic [PTR_W-1:0] w_head_fire;
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic             w_err_rel;
    logic             w_err_walk;
    logic             w_err_fire;

`ifdef FREELIST_SNAPSHOT_EN
    logic [PTR_W-1:0] r_snap [SNAP_NUM];
    assign w_restore = snap_restore;
`else
    assign w_restore = 1'b0;
`endif

    assign w_free_count = r_tail - r_head;

    // Requesting lanes are compacted: lane i takes the slot at head plus the
    // number of requesting lanes below it, so sparse masks get dense pregs.
    always_comb begin
        w_alloc_cnt = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            w_alloc_idx[i] = r_head[IDX_W-1:0] + IDX_W'(w_alloc_cnt);
            if (alloc_req[i]) begin
                w_alloc_cnt = w_alloc_cnt + AC_W'(1);
            end
        end
    end

    // Same compaction on the release side, relative to tail.
    always_comb begin
        w_free_cnt = '0;
        for (int j = 0; j < FREE_W; j++) begin
            w_free_idx[j] = r_tail[IDX_W-1:0] + IDX_W'(w_free_cnt);
            if (free_en[j]) begin
                w_free_cnt = w_free_cnt + FC_W'(1);
            end
        end
    end

    always_comb begin
        alloc_preg = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            alloc_preg[i*IDX_W +: IDX_W] = r_list[w_alloc_idx[i]];
        end
    end

    assign w_ready     = (w_free_count >= PTR_W'(w_alloc_cnt)) && !walk_en && !w_restore;
    assign w_fire      = w_ready && !stall && (|alloc_req);
    assign w_walk      = walk_en && !w_restore;
    assign w_head_fire = r_head + (w_fire ? PTR_W'(w_alloc_cnt) : PTR_W'(0));
    assign w_tail_nxt  = r_tail + PTR_W'(w_free_cnt);

    // Head priority: checkpoint restore, then walk-back, then allocation.
    always_comb begin
        w_head_nxt = r_head;
`ifdef FREELIST_SNAPSHOT_EN
        if (snap_restore) begin
            w_head_nxt = r_snap[restore_id];
        end else
`endif
        if (w_walk) begin
            w_head_nxt = r_head - PTR_W'(walk_num);
        end else if (w_fire) begin
            w_head_nxt = w_head_fire;
        end
    end

    // Release overflow is judged against the free count at the start of the
    // cycle: a preg allocated this cycle cannot also be committed this cycle.
    assign w_err_rel  = ({1'b0, w_free_count} + (PTR_W+1)'(w_free_cnt)) > (PTR_W+1)'(DEPTH);
    assign w_err_walk = w_walk &&
                        (({1'b0, w_free_count} + (PTR_W+1)'(walk_num)) > (PTR_W+1)'(DEPTH));
    assign w_err_fire = w_fire && (PTR_W'(w_alloc_cnt) > w_free_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= PTR_W'(DEPTH);
            r_err  <= 1'b0;
        end else begin
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
            if (w_err_rel || w_err_walk || w_err_fire) begin
                r_err <= 1'b1;
            end
        end
    end

    // Slots behind head keep their contents until tail reaches them again,
    // which is what makes walk-back return the identical pregs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PREG_NUM; i++) begin
                r_list[i] <= (i < DEPTH) ? IDX_W'(ARCH_NUM + i) : '0;
            end
        end else begin
            for (int j = 0; j < FREE_W; j++) begin
                if (free_en[j]) begin
                    r_list[w_free_idx[j]] <= free_preg[j*IDX_W +: IDX_W];
                end
            end
        end
    end

`ifdef FREELIST_SNAPSHOT_EN
    // A take records head as it will be after this cycle's allocation, so the
    // checkpoint lines up with the instruction group renamed in this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SNAP_NUM; s++) begin
                r_snap[s] <= '0;
            end
        end else if (snap_take && !snap_restore) begin
            r_snap[snap_id] <= w_head_fire;
        end
    end
`endif

    assign alloc_ready = w_ready;
    assign free_count  = w_free_count;
    assign err         = r_err;

endmodule

// File: tb/tb_preg_freelist_ckpt.sv
module tb_preg_freelist_ckpt;
    localparam int IDX   = 7;
    localparam int DEPTH = 96;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alloc_req;
    logic        stall;
    logic        alloc_ready;
    logic [27:0] alloc_preg;
    logic [3:0]  free_en;
    logic [27:0] free_preg;
    logic        walk_en;
    logic [2:0]  walk_num;
    logic [7:0]  free_count;
    logic        err;
`ifdef FREELIST_SNAPSHOT_EN
    logic        snap_take;
    logic [2:0]  snap_id;
    logic        snap_restore;
    logic [2:0]  restore_id;
`endif

    preg_freelist_ckpt dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .stall(stall),
        .alloc_ready(alloc_ready), .alloc_preg(alloc_preg),
        .free_en(free_en), .free_preg(free_preg),
        .walk_en(walk_en), .walk_num(walk_num),
        .free_count(free_count), .err(err)
`ifdef FREELIST_SNAPSHOT_EN
        , .snap_take(snap_take), .snap_id(snap_id),
        .snap_restore(snap_restore), .restore_id(restore_id)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  req;
        logic        stall;
        logic [3:0]  fen;
        logic [27:0] fpreg;
        logic        walk;
        logic [2:0]  wn;
        logic        exp_ready;
        logic [27:0] exp_preg;
        int          exp_fc;
    } vec_t;

    vec_t vecs[9];

    // Reference model: ordered list of free pregs and the allocation history.
    int fq[$];
    int hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [27:0] p4(input int a, input int b, input int c, input int d);
        logic [6:0] la, lb, lc, ld;
        la = 7'(a); lb = 7'(b); lc = 7'(c); ld = 7'(d);
        return {ld, lc, lb, la};
    endfunction

    function automatic int lane(input int i);
        return int'(alloc_preg[i*IDX +: IDX]);
    endfunction

    task automatic idle();
        alloc_req = '0; stall = 1'b0; free_en = '0; free_preg = '0;
        walk_en = 1'b0; walk_num = '0;
`ifdef FREELIST_SNAPSHOT_EN
        snap_take = 1'b0; snap_id = '0; snap_restore = 1'b0; restore_id = '0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fq.delete();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) fq.push_back(32 + i);
    endtask

    task automatic chk_lanes(input string tag, input logic [3:0] req, input logic [27:0] exp);
        for (int i = 0; i < 4; i++) begin
            if (req[i]) chk($sformatf("%s_lane%0d", tag, i), 32'(lane(i)), 32'(exp[i*IDX +: IDX]));
        end
    endtask

    task automatic run_random(input int ncyc);
        int fc, inflight, wn, maxf, pre;
        logic [3:0] req, fen;
        logic walk, exp_ready;
        for (int c = 0; c < ncyc; c++) begin
            fc = fq.size();
            inflight = DEPTH - fc;
            req = 4'($urandom);
            walk = (($urandom % 8) == 0) && (inflight > 0);
            wn = walk ? int'($urandom_range(0, (inflight < 4) ? inflight : 4)) : 0;
            maxf = DEPTH - fc - wn;
            fen = (($urandom % 3) == 0) ? 4'($urandom) : 4'b0;
            while ($countones(fen) > maxf) fen = fen & (fen - 4'd1);
            alloc_req = req;
            stall = (($urandom % 4) == 0);
            walk_en = walk;
            walk_num = 3'(wn);
            free_en = fen;
            free_preg = 28'($urandom);
            exp_ready = (fc >= $countones(req)) && !walk;
            #4;
            chk($sformatf("rnd%0d_ready", c), 32'(alloc_ready), 32'(exp_ready));
            if (exp_ready) begin
                pre = 0;
                for (int i = 0; i < 4; i++) begin
                    if (req[i]) begin
                        chk($sformatf("rnd%0d_lane%0d", c, i), 32'(lane(i)), 32'(fq[pre]));
                        pre++;
                    end
                end
            end
            if (exp_ready && !stall && (req != 0)) begin
                for (int i = 0; i < $countones(req); i++) hist.push_back(fq.pop_front());
            end
            if (walk) begin
                for (int i = 0; i < wn; i++) fq.push_front(hist.pop_back());
            end
            for (int j = 0; j < 4; j++) begin
                if (fen[j]) fq.push_back(int'(free_preg[j*IDX +: IDX]));
            end
            tick();
            chk($sformatf("rnd%0d_fc", c), 32'(free_count), 32'(fq.size()));
            chk($sformatf("rnd%0d_err", c), 32'(err), 32'd0);
        end
        idle();
    endtask

    initial begin
        // Table: consecutive cycles starting from the reset state.
        vecs[0] = '{4'b1111, 1'b0, 4'b0000, '0,             1'b0, 3'd0, 1'b1, p4(32,33,34,35), 92};
        vecs[1] = '{4'b1010, 1'b0, 4'b0000, '0,             1'b0, 3'd0, 1'b1, p4(0,36,0,37),   90};
        vecs[2] = '{4'b1111, 1'b1, 4'b0000, '0,             1'b0, 3'd0, 1'b1, p4(38,39,40,41), 90};
        vecs[3] = '{4'b0000, 1'b0, 4'b0011, p4(5,6,0,0),    1'b0, 3'd0, 1'b1, '0,              92};
        vecs[4] = '{4'b0101, 1'b0, 4'b0000, '0,             1'b1, 3'd2, 1'b0, '0,              94};
        vecs[5] = '{4'b0101, 1'b0, 4'b0000, '0,             1'b0, 3'd0, 1'b1, p4(36,0,37,0),   92};
        vecs[6] = '{4'b1001, 1'b0, 4'b0100, p4(0,0,9,0),    1'b0, 3'd0, 1'b1, p4(38,0,0,39),   91};
        vecs[7] = '{4'b0000, 1'b0, 4'b0000, '0,             1'b1, 3'd4, 1'b0, '0,              95};
        vecs[8] = '{4'b1111, 1'b0, 4'b0000, '0,             1'b0, 3'd0, 1'b1, p4(36,37,38,39), 91};

        idle();
        rst = 1'b1;
        repeat (2) tick();
        do_reset();

        // Reset state
        #4;
        chk("rst_fc", 32'(free_count), 32'd96);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        tick();

        // Table-driven sequence
        do_reset();
        for (int k = 0; k < 9; k++) begin
            alloc_req = vecs[k].req; stall = vecs[k].stall;
            free_en = vecs[k].fen; free_preg = vecs[k].fpreg;
            walk_en = vecs[k].walk; walk_num = vecs[k].wn;
            #4;
            chk($sformatf("tbl%0d_ready", k), 32'(alloc_ready), 32'(vecs[k].exp_ready));
            if (vecs[k].exp_ready) chk_lanes($sformatf("tbl%0d", k), vecs[k].req, vecs[k].exp_preg);
            tick();
            chk($sformatf("tbl%0d_fc", k), 32'(free_count), 32'(vecs[k].exp_fc));
            chk($sformatf("tbl%0d_err", k), 32'(err), 32'd0);
        end
        idle();

        // T2: sparse mask from reset
        do_reset();
        alloc_req = 4'b1010;
        #4;
        chk_lanes("t2", 4'b1010, p4(0,32,0,33));
        tick();
        chk("t2_fc", 32'(free_count), 32'd94);

        // T3: drain to two entries, over-request, then one release
        do_reset();
        alloc_req = 4'b1111;
        repeat (23) tick();
        alloc_req = 4'b0011;
        tick();
        chk("t3_drain_fc", 32'(free_count), 32'd2);
        alloc_req = 4'b0111;
        #4;
        chk("t3_ready_low", 32'(alloc_ready), 32'd0);
        tick();
        chk("t3_head_held", 32'(free_count), 32'd2);
        free_en = 4'b0001; free_preg = p4(7,0,0,0);
        #4;
        chk("t3_ready_low2", 32'(alloc_ready), 32'd0);
        tick();
        free_en = 4'b0000;
        #4;
        chk("t3_ready_high", 32'(alloc_ready), 32'd1);
        chk_lanes("t3", 4'b0111, p4(126,127,7,0));
        tick();
        chk("t3_empty_fc", 32'(free_count), 32'd0);
        alloc_req = 4'b0001;
        #4;
        chk("t3_empty_ready", 32'(alloc_ready), 32'd0);
        tick();
        idle();

        // T4: walk-back returns identical pregs; allocation blocked during walk
        do_reset();
        alloc_req = 4'b0111;
        #4;
        chk_lanes("t4a", 4'b0111, p4(32,33,34,0));
        tick();
        alloc_req = 4'b1111; walk_en = 1'b1; walk_num = 3'd3;
        #4;
        chk("t4_walk_ready", 32'(alloc_ready), 32'd0);
        tick();
        chk("t4_walk_fc", 32'(free_count), 32'd96);
        walk_en = 1'b0; alloc_req = 4'b0111;
        #4;
        chk("t4_ready", 32'(alloc_ready), 32'd1);
        chk_lanes("t4b", 4'b0111, p4(32,33,34,0));
        tick();
        chk("t4_fc", 32'(free_count), 32'd93);
        chk("t4_err", 32'(err), 32'd0);
        idle();

        // T5: release overflow sets a sticky err; walk underflow also sets it
        do_reset();
        free_en = 4'b1111; free_preg = p4(1,2,3,4);
        tick();
        free_en = 4'b0000;
        chk("t5_err_set", 32'(err), 32'd1);
        alloc_req = 4'b1111;
        repeat (5) tick();
        chk("t5_err_sticky", 32'(err), 32'd1);
        do_reset();
        chk("t5_err_clr", 32'(err), 32'd0);
        chk("t5_fc_clr", 32'(free_count), 32'd96);
        walk_en = 1'b1; walk_num = 3'd1;
        tick();
        walk_en = 1'b0;
        chk("t5_walk_err", 32'(err), 32'd1);
        do_reset();
        chk("t5_walk_err_clr", 32'(err), 32'd0);

`ifdef FREELIST_SNAPSHOT_EN
        // T6: checkpoint take / restore
        do_reset();
        alloc_req = 4'b1111; snap_take = 1'b1; snap_id = 3'd2;
        tick();
        snap_take = 1'b0;
        repeat (2) tick();
        chk("t6_fc_pre", 32'(free_count), 32'd84);
        snap_restore = 1'b1; restore_id = 3'd2; snap_take = 1'b1; snap_id = 3'd2;
        #4;
        chk("t6_restore_ready", 32'(alloc_ready), 32'd0);
        tick();
        snap_restore = 1'b0; snap_take = 1'b0;
        chk("t6_fc_post", 32'(free_count), 32'd92);
        alloc_req = 4'b0001;
        #4;
        chk_lanes("t6", 4'b0001, p4(36,0,0,0));
        tick();
        idle();
        alloc_req = 4'b0000; snap_restore = 1'b1; restore_id = 3'd2;
        tick();
        snap_restore = 1'b0;
        chk("t6_take_dropped", 32'(free_count), 32'd92);
        idle();
`endif

        // Randomized run against the reference model
        do_reset();
        run_random(600);

        // Mid-operation reset
        alloc_req = 4'b1111; free_en = 4'b1111; walk_en = 1'b1; walk_num = 3'd4; rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        #4;
        chk("midrst_fc", 32'(free_count), 32'd96);
        chk("midrst_err", 32'(err), 32'd0);
        alloc_req = 4'b0001;
        #1;
        chk_lanes("midrst", 4'b0001, p4(32,0,0,0));
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
